fifo_wr_arb: RTL
================

Name: fifo_wr_arb

Overview:
- Round-robin, packet-atomic arbiter that shares the single write port of the FIFO among NREQ requesters.
- Sits in the write clock domain, in front of the FIFO write-pointer logic.
- Drives winc/wdata from the granted requester and never issues winc while full.
- Enforces a maximum packet length and flags violations.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, data width per beat
MAXBEAT, 16, maximum beats per packet before forced termination (2..255)

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester beat valid
req_last  in  NREQ  per-requester last beat of packet
req_data  in  NREQ*DSIZE  per-requester beat data, requester i in bits [i*DSIZE +: DSIZE]
req_ready  out  NREQ  per-requester beat accepted
full  in  1  FIFO full
near_full  in  1  FIFO has exactly one free entry (mutually exclusive with full)
winc  out  1  FIFO write strobe
wdata  out  DSIZE  FIFO write data
grant  out  NREQ  one-hot current owner, 0 when idle
busy  out  1  packet in progress
len_err  out  1  sticky: packet exceeded MAXBEAT
err_id  out  3  index of the requester that caused the first len_err

Behaviour:
- Clocking and reset: single clock clk. Reset is asynchronous and active-low (rst_n).
- Reset values: grant=0, busy=0, len_err=0, err_id=0, rr_ptr=NREQ-1 (requester 0 has highest priority first), beat_cnt=0, state=IDLE.
- States:
  - IDLE: if |req_valid & !full & !near_full, pick the first requester with valid, scanning from rr_ptr+1 modulo NREQ. Register its one-hot grant, go to BURST, beat_cnt=0.
  - IDLE with full or near_full asserted: no new grant. A packet starts only with at least 2 free entries.
  - BURST: req_ready[i] = grant[i] & !full (combinational). winc = |(req_valid & req_ready). wdata = req_data of the granted requester (registered grant, combinational mux). Non-granted ready=0.
  - BURST, on an accepted beat: beat_cnt++. If req_last is accepted, or beat_cnt reaches MAXBEAT-1 on an accepted non-last beat: clear grant, rr_ptr = granted index, go to IDLE.
  - Forced termination at MAXBEAT: also set len_err=1. Load err_id only if len_err was 0.
- Arbitration latency: 1 idle cycle between packets. First beat can transfer in the cycle after grant (2 cycles from valid to first winc).
- busy = (state==BURST).
- Full mid-packet: the grant is held and ready is deasserted. The requester holds data. No other requester is granted; the packet stays atomic.
- Owner drops valid mid-packet: grant is held indefinitely with no timeout, and beat_cnt is unchanged.
- Simultaneous req_last with full=1: not accepted; the packet continues until it is accepted.
- Invariants: winc & full never true. grant is $onehot0. winc implies busy.
- Reset mid-packet: immediate return to reset values. FIFO contents are not the arbiter's concern.
- Width rules: beat_cnt is $clog2(MAXBEAT+1) bits. rr_ptr is $clog2(NREQ) bits with wrap at NREQ-1 → 0. err_id is zero-extended.

Test Plan:
- Reset, then req_valid=4'b1111, single-beat packets (last=1), full=0, near_full=0 → grants in order 0,1,2,3,0. One winc every 2 cycles. wdata matches the granted requester.
- Requester 2 sends a 5-beat packet while requesters 0 and 3 are valid → 5 consecutive winc with grant=4'b0100, then the next grant goes to 3, then 0.
- Mid-packet, full=1 for 3 cycles → winc=0 and req_ready=0 for those 3 cycles, grant unchanged. Transfer resumes the cycle full drops, with no beat lost or duplicated.
- IDLE with near_full=1 and req_valid=4'b0001 → no grant. When near_full drops → grant=4'b0001 next cycle.
- Requester 1 streams 20 beats with no last, MAXBEAT=16 → exactly 16 winc, then grant cleared, len_err=1, err_id=1. A later overrun by requester 3 leaves err_id=1.
- rst_n pulsed low during beat 3 of a packet → grant, busy and winc drop immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between NREQ requesters, the arbiter and the FIFO write port.
// master: requester/FIFO side that drives beats and full flags; slave: the arbiter.
`timescale 1ns/1ps
interface fifo_wr_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  full;
  logic                  near_full;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  len_err;
  logic [2:0]            err_id;

  modport master (
    output req_valid, req_last, req_data, full, near_full,
    input  req_ready, winc, wdata, grant, busy, len_err, err_id
  );

  modport slave (
    input  req_valid, req_last, req_data, full, near_full,
    output req_ready, winc, wdata, grant, busy, len_err, err_id
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port among NREQ requesters.
// A packet starts only with two free entries and is force-ended after MAXBEAT beats.
`timescale 1ns/1ps
module fifo_wr_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned MAXBEAT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_wr_arb_if.slave  bus
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAXBEAT + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PtrW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              len_err_q, len_err_d;
  logic [2:0]        err_id_q, err_id_d;

  logic              pick_found;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW-1:0]   cand;
  logic [NREQ-1:0]   ready;
  logic              accept;
  logic              owner_last;

  // First valid requester scanning upward from the one after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % NREQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign ready      = grant_q & {NREQ{~bus.full}};
  assign accept     = |(bus.req_valid & ready);
  assign owner_last = bus.req_last[gnt_idx_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    err_id_d   = err_id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found && !bus.full && !bus.near_full) begin
          state_d    = StBurst;
          grant_d    = NREQ'(1) << pick_idx;
          gnt_idx_d  = pick_idx;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (owner_last || beat_cnt_q == CntW'(MAXBEAT - 1)) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = gnt_idx_q;
            // Overrun: only the first offender is recorded.
            if (!owner_last) begin
              len_err_d = 1'b1;
              if (!len_err_q) err_id_d = 3'(gnt_idx_q);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= PtrW'(NREQ - 1);
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
      err_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.winc      = accept;
  assign bus.wdata     = bus.req_data[gnt_idx_q*DSIZE +: DSIZE];
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == StBurst);
  assign bus.len_err   = len_err_q;
  assign bus.err_id    = err_id_q;

endmodule
